// File: rtl/puf_pkg.sv
// Shared types and helpers for the arbiter-PUF challenge sequencer:
// widths, LFSR taps, FSM state encoding and response packing.
package puf_pkg;

    localparam int CHAL_W = 8;
    localparam int RESP_W = 7;
    localparam logic [CHAL_W-1:0] LFSR_TAPS = 8'hB8;
    localparam logic [CHAL_W-1:0] LFSR_INIT = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_PULSE   = 3'd2,
        ST_HOLD    = 3'd3,
        ST_EVAL    = 3'd4,
        ST_PRESENT = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    function automatic logic [15:0] pack_resp(input logic [CHAL_W-1:0] chal,
                                              input logic [RESP_W-1:0] resp);
        return {chal, 1'b0, resp};
    endfunction

    // Fibonacci x^8+x^6+x^5+x^4+1: feedback is the parity of the tapped bits.
    function automatic logic [CHAL_W-1:0] lfsr_next(input logic [CHAL_W-1:0] c);
        return {c[CHAL_W-2:0], ^(c & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// Valid/ready channel carrying {challenge, 0, response} pairs downstream.
interface puf_challenge_sequencer_if;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;

    modport master (output resp_valid, output resp_data, input resp_ready);
    modport slave  (input resp_valid, input resp_data, output resp_ready);
endinterface

// File: rtl/puf_vote_acc.sv
// Per-bit majority counters over repeated PUF evaluations of one challenge.
module puf_vote_acc #(
    parameter int RESP_W  = 7,
    parameter int REPEATS = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_acc,
    input  logic [RESP_W-1:0] i_resp,
    output logic [RESP_W-1:0] o_result
);
    localparam int CW = $clog2(REPEATS + 1);
    localparam logic [CW-1:0] HALF = CW'(REPEATS / 2);

    logic [CW-1:0] r_cnt [RESP_W];

    // Count ones seen on each response bit since the last clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RESP_W; i++) r_cnt[i] <= {CW{1'b0}};
        end else if (i_clear) begin
            for (int i = 0; i < RESP_W; i++) r_cnt[i] <= {CW{1'b0}};
        end else if (i_acc) begin
            for (int i = 0; i < RESP_W; i++) r_cnt[i] <= r_cnt[i] + CW'(i_resp[i]);
        end
    end

    // Strict majority of an odd repeat count.
    always_comb begin
        o_result = {RESP_W{1'b0}};
        for (int i = 0; i < RESP_W; i++) o_result[i] = (r_cnt[i] > HALF);
    end
endmodule

// File: rtl/puf_challenge_sequencer.sv
// Arbiter-PUF initiator: LFSR challenges, settle/pulse/hold timing, response
// capture and valid/ready hand-off. Majority voting under PUF_MAJORITY_VOTE_EN.
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int PULSE_CYCLES  = 2,
    parameter int REPEATS       = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [CHAL_W-1:0]         seed,
    input  logic [7:0]                num_chal,
    output logic [CHAL_W-1:0]         challenge_o,
    output logic                      pulse_o,
    input  logic [RESP_W-1:0]         response_i,
    puf_challenge_sequencer_if.master rsp,
    output logic                      busy,
    output logic                      done
);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] PULSE_LAST  = 16'(PULSE_CYCLES - 1);
    localparam int          EVAL_W      = $clog2(REPEATS + 1);
`ifdef PUF_MAJORITY_VOTE_EN
    localparam logic [EVAL_W-1:0] N_EVAL = EVAL_W'(REPEATS);
`else
    localparam logic [EVAL_W-1:0] N_EVAL = EVAL_W'(1);
`endif

    state_t              r_state, w_next;
    logic [15:0]         r_cnt;
    logic [EVAL_W-1:0]   r_eval;
    logic [8:0]          r_pair;
    logic [CHAL_W-1:0]   r_lfsr, r_chal;
    logic [15:0]         r_data;
    logic                r_busy, r_pulse, r_valid, r_done;
    logic [CHAL_W-1:0]   w_seed, w_lfsr_nxt;
    logic [8:0]          w_target, w_pair_inc;
    logic                w_load, w_advance, w_clear, w_sample, w_latch;
    logic [RESP_W-1:0]   w_result;

    assign w_seed     = (seed == {CHAL_W{1'b0}}) ? LFSR_INIT : seed;
    assign w_lfsr_nxt = lfsr_next(r_lfsr);
    assign w_target   = (num_chal == 8'd0) ? 9'd256 : {1'b0, num_chal};
    assign w_pair_inc = r_pair + 9'd1;
    assign w_load     = (r_state == ST_IDLE) && (w_next == ST_SETTLE);
    assign w_advance  = (r_state == ST_PRESENT) && (w_next == ST_SETTLE);
    assign w_clear    = w_load || w_advance;
    assign w_sample   = (r_state == ST_HOLD) && (w_next == ST_EVAL);
    assign w_latch    = (r_state == ST_EVAL) && (w_next == ST_PRESENT);

    // Next-state selection; abort overrides every non-IDLE transition.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (start && !abort) w_next = ST_SETTLE; else w_next = ST_IDLE;
            ST_SETTLE:  if (r_cnt == SETTLE_LAST) w_next = ST_PULSE; else w_next = ST_SETTLE;
            ST_PULSE:   if (r_cnt == PULSE_LAST) w_next = ST_HOLD; else w_next = ST_PULSE;
            ST_HOLD:    if (r_cnt == SETTLE_LAST) w_next = ST_EVAL; else w_next = ST_HOLD;
            ST_EVAL:    if (r_eval < N_EVAL) w_next = ST_SETTLE; else w_next = ST_PRESENT;
            ST_PRESENT: begin
                if (rsp.resp_ready) begin
                    if (w_pair_inc == w_target) w_next = ST_DONE; else w_next = ST_SETTLE;
                end else begin
                    w_next = ST_PRESENT;
                end
            end
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
        if (abort && (r_state != ST_IDLE)) w_next = ST_IDLE;
    end

    // State, phase counter and the registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 16'd0;
            r_busy  <= 1'b0;
            r_pulse <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? 16'd0 : r_cnt + 16'd1;
            r_busy  <= (w_next != ST_IDLE);
            r_pulse <= (w_next == ST_PULSE);
            r_valid <= (w_next == ST_PRESENT);
            r_done  <= (w_next == ST_DONE);
        end
    end

    // Challenge only moves on entry to SETTLE, so it is frozen through PULSE/HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_INIT;
            r_chal <= {CHAL_W{1'b0}};
            r_pair <= 9'd0;
            r_eval <= {EVAL_W{1'b0}};
            r_data <= 16'd0;
        end else begin
            if (w_load) begin
                r_lfsr <= w_seed;
                r_chal <= w_seed;
                r_pair <= 9'd0;
            end else if (w_advance) begin
                r_lfsr <= w_lfsr_nxt;
                r_chal <= w_lfsr_nxt;
                r_pair <= w_pair_inc;
            end else if ((r_state == ST_PRESENT) && (w_next == ST_DONE)) begin
                r_pair <= w_pair_inc;
            end
            if (w_clear) r_eval <= {EVAL_W{1'b0}};
            else if (w_sample) r_eval <= r_eval + EVAL_W'(1);
            if (w_latch) r_data <= pack_resp(r_lfsr, w_result);
        end
    end

`ifdef PUF_MAJORITY_VOTE_EN
    puf_vote_acc #(
        .RESP_W  (RESP_W),
        .REPEATS (REPEATS)
    ) u_vote (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_acc    (w_sample),
        .i_resp   (response_i),
        .o_result (w_result)
    );
`else
    logic [RESP_W-1:0] r_sample;

    // Single evaluation: the last HOLD-cycle sample is the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sample <= {RESP_W{1'b0}};
        else if (w_sample) r_sample <= response_i;
    end
    assign w_result = r_sample;
`endif

    assign challenge_o    = r_chal;
    assign pulse_o        = r_pulse;
    assign busy           = r_busy;
    assign done           = r_done;
    assign rsp.resp_valid = r_valid;
    assign rsp.resp_data  = r_data;
endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench for puf_challenge_sequencer; covers the vote path when
// PUF_MAJORITY_VOTE_EN is defined.
module tb_puf_challenge_sequencer;
    import puf_pkg::*;

    logic              clk = 1'b0;
    logic              rst, start, abort;
    logic [CHAL_W-1:0] seed;
    logic [7:0]        num_chal;
    logic [CHAL_W-1:0] challenge_o;
    logic              pulse_o;
    logic [RESP_W-1:0] response_i;
    logic              busy, done;
    int                total = 0;
    int                bad = 0;

`ifdef PUF_MAJORITY_VOTE_EN
    localparam int EVAL_T = 55;
    logic [RESP_W-1:0] vote_pat [5] = '{7'h05, 7'h07, 7'h04, 7'h06, 7'h05};
`else
    localparam int EVAL_T = 11;
`endif

    puf_challenge_sequencer_if rsp_if ();

    puf_challenge_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .seed        (seed),
        .num_chal    (num_chal),
        .challenge_o (challenge_o),
        .pulse_o     (pulse_o),
        .response_i  (response_i),
        .rsp         (rsp_if.master),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Waits for resp_valid, checking the challenge never moves meanwhile.
    task automatic wait_valid(input logic [7:0] exp_chal, output int n);
        n = 0;
        while (!rsp_if.resp_valid && n < 400) begin
            tick();
            n++;
            chk("chal_stable", challenge_o, exp_chal);
        end
        chk("valid_seen", rsp_if.resp_valid, 1'b1);
    endtask

    initial begin
        int n;
        logic seen;
        logic [7:0] chals [4] = '{8'h01, 8'h02, 8'h04, 8'h08};

        rst = 1'b1; start = 1'b0; abort = 1'b0; seed = 8'h00; num_chal = 8'd0;
        response_i = 7'h00; rsp_if.resp_ready = 1'b0;
        tick(); tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_pulse", pulse_o, 1'b0);
        chk("rst_valid", rsp_if.resp_valid, 1'b0);
        chk("rst_chal", challenge_o, 8'h00);
        chk("rst_data", rsp_if.resp_data, 16'h0000);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;
        tick();

        // Seed 0 -> 0x01, four pairs, ready tied high.
        seed = 8'h00; num_chal = 8'd4; response_i = 7'h55; rsp_if.resp_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        chk("a_busy", busy, 1'b1);
        chk("a_chal0", challenge_o, 8'h01);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("a_settle_pulse_low", pulse_o, 1'b0);
        end
        tick();
        chk("a_pulse_rise", pulse_o, 1'b1);
        wait_valid(8'h01, n);
        chk("a_first_latency", n, EVAL_T - 4);
        chk("a_data0", rsp_if.resp_data, 16'h0155);
        for (int p = 1; p < 4; p++) begin
            tick();
            chk("a_valid_drop", rsp_if.resp_valid, 1'b0);
            wait_valid(chals[p], n);
            chk("a_latency", n, EVAL_T);
            chk("a_data", rsp_if.resp_data, {chals[p], 1'b0, 7'h55});
        end
        tick();
        chk("a_done", done, 1'b1);
        chk("a_done_valid", rsp_if.resp_valid, 1'b0);
        tick();
        chk("a_done_once", done, 1'b0);
        chk("a_idle", busy, 1'b0);

        // Seed 0x08: LFSR step to 0x11.
        seed = 8'h08; num_chal = 8'd2; response_i = 7'h2A;
        start = 1'b1; tick(); start = 1'b0;
        wait_valid(8'h08, n);
        chk("b_data0", rsp_if.resp_data, 16'h082A);
        tick();
        wait_valid(8'h11, n);
        chk("b_data1", rsp_if.resp_data, 16'h112A);
        tick();
        chk("b_done", done, 1'b1);
        tick();

        // Backpressure: output held, no pulse activity for 20 cycles.
        seed = 8'h33; num_chal = 8'd1; response_i = 7'h7F; rsp_if.resp_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        wait_valid(8'h33, n);
        response_i = 7'h00;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!rsp_if.resp_valid || pulse_o || rsp_if.resp_data != 16'h337F) seen = 1'b1;
        end
        chk("c_held", seen, 1'b0);
        chk("c_data", rsp_if.resp_data, 16'h337F);
        rsp_if.resp_ready = 1'b1;
        tick();
        chk("c_done", done, 1'b1);
        tick();

`ifdef PUF_MAJORITY_VOTE_EN
        // bit0: 1,1,0,0,1 -> 1; bit1: 0,1,0,1,0 -> 0; bit2 always 1.
        seed = 8'h01; num_chal = 8'd1;
        start = 1'b1; tick(); start = 1'b0;
        for (int e = 0; e < 5; e++) begin
            n = 0;
            while (!pulse_o && n < 60) begin tick(); n++; end
            chk("v_pulse_seen", pulse_o, 1'b1);
            response_i = vote_pat[e];
            n = 0;
            while (pulse_o && n < 60) begin tick(); n++; end
        end
        wait_valid(8'h01, n);
        chk("v_data", rsp_if.resp_data, 16'h0105);
        tick();
        chk("v_done", done, 1'b1);
        tick();
`endif

        // Abort during HOLD of the second challenge.
        seed = 8'h05; num_chal = 8'd3; response_i = 7'h11;
        start = 1'b1; tick(); start = 1'b0;
        wait_valid(8'h05, n);
        chk("d_data0", rsp_if.resp_data, 16'h0511);
        tick();
        chk("d_chal1", challenge_o, 8'h0A);
        for (int i = 0; i < 7; i++) tick();
        chk("d_hold_pulse", pulse_o, 1'b0);
        chk("d_hold_busy", busy, 1'b1);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("d_abort_busy", busy, 1'b0);
        chk("d_abort_pulse", pulse_o, 1'b0);
        chk("d_abort_valid", rsp_if.resp_valid, 1'b0);
        chk("d_abort_done", done, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_if.resp_valid || done || pulse_o) seen = 1'b1;
        end
        chk("d_quiet", seen, 1'b0);
        start = 1'b1; abort = 1'b1; tick(); abort = 1'b0;
        chk("d_start_abort_idle", busy, 1'b0);
        tick(); start = 1'b0;
        chk("d_restart_busy", busy, 1'b1);
        chk("d_restart_chal", challenge_o, 8'h05);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("d_end_idle", busy, 1'b0);

        // Asynchronous reset in the middle of PULSE.
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("e_pulse_high", pulse_o, 1'b1);
        rst = 1'b1;
        #2;
        chk("e_async_pulse", pulse_o, 1'b0);
        chk("e_async_busy", busy, 1'b0);
        chk("e_async_valid", rsp_if.resp_valid, 1'b0);
        chk("e_async_chal", challenge_o, 8'h00);
        chk("e_async_data", rsp_if.resp_data, 16'h0000);
        rst = 1'b0;
        tick(); tick();
        chk("e_idle_busy", busy, 1'b0);
        chk("e_idle_pulse", pulse_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/puf_challenge_sequencer.md
# puf_challenge_sequencer

Initiator side of the arbiter-PUF challenge/response interface. It generates an LFSR-driven sequence of 8-bit challenges and fires the launch pulse into the PUF array. It samples the 7-bit response after a settle window and hands each {challenge, response} pair to the downstream consumer over a valid/ready handshake. It sits between the top-level control inputs and the PUF array, replacing direct pin drive of the challenge and pulse.

## Interface
- `CHAL_W`, 8: challenge width; matches the PUF mux-chain length.
- `RESP_W`, 7: response width; one bit per PUF instance.
- `SETTLE_CYCLES`, 4: cycles the challenge is held stable before the pulse, and again after the pulse before sampling; ≥1.
- `PULSE_CYCLES`, 2: cycles `pulse_o` stays high per evaluation; ≥1.
- `REPEATS`, 5: evaluations per challenge when voting is compiled in; odd, ≥1.

Ports:
- `clk` in 1: single clock. All logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a run; sampled only in IDLE.
- `abort` in 1: terminate the run; returns to IDLE next cycle and does not pulse `done`.
- `seed` in CHAL_W: first challenge; 0 is replaced by 8'h01.
- `num_chal` in 8: challenges per run; 0 means 256.
- `challenge_o` out CHAL_W: drives PUF `ichallenge`.
- `pulse_o` out 1: drives PUF `ipulse`.
- `response_i` in RESP_W: PUF `oresponse`.
- `resp_valid` out 1, `resp_ready` in 1: output handshake.
- `resp_data` out 16: {challenge[7:0], 1'b0, response[6:0]}.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse after the last pair is accepted.

## Operation
- States and transitions:
  - IDLE → SETTLE on `start`: load challenge = seed (0→0x01), clear pair count, clear vote counters.
  - SETTLE (SETTLE_CYCLES, pulse low) → PULSE.
  - PULSE (PULSE_CYCLES, pulse high) → HOLD.
  - HOLD (SETTLE_CYCLES, pulse low). On HOLD's last cycle, register `response_i` into the accumulator → EVAL.
  - EVAL: if evaluations < REPEATS → SETTLE; otherwise latch the result → PRESENT.
  - PRESENT: `resp_valid`=1; `resp_data` is stable until `resp_ready`. On handshake: count+1; if count == num_chal → DONE, else advance LFSR and clear vote counters → SETTLE.
  - DONE: `done`=1 for one cycle → IDLE.
- LFSR: Fibonacci, x^8+x^6+x^5+x^4+1. fb = c[7]^c[5]^c[4]^c[3]; next = {c[6:0], fb}. It never reaches 0.
- `challenge_o` changes only on entry to SETTLE, never while the pulse is high or during HOLD.
- `abort` has priority over every transition in any non-IDLE state. It forces IDLE with `pulse_o`=0 and `resp_valid`=0 on the next edge.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE: `abort` wins, stay IDLE.
- `rst` clears everything immediately: state IDLE, `challenge_o`=0, `pulse_o`=0, `resp_valid`=0, `resp_data`=0, `busy`=0, `done`=0, LFSR=0x01, counters=0.

## Timing
- `start` at edge N → `busy` and `challenge_o` valid from N+1. `pulse_o` rises at N+1+SETTLE_CYCLES.
- Single evaluation: SETTLE+PULSE+HOLD+1 (EVAL) cycles, which is 11 with defaults. `resp_valid` rises the cycle after EVAL.
- With voting, a challenge takes REPEATS × 11 cycles before PRESENT.
- All outputs are registered; there is no combinational path from `resp_ready` to `resp_valid`.

## Configuration
- `PUF_MAJORITY_VOTE_EN` defined:
  - Each response bit has a counter of width clog2(REPEATS+1).
  - Result bit = count > REPEATS/2.
- Undefined:
  - REPEATS is ignored and treated as 1.
  - The result is the single sampled response.
  - No vote counters are built.

## Structure
- Shared package `puf_pkg`: CHAL_W, RESP_W, LFSR tap mask 8'hB8, the state enum typedef, and the `resp_data` packing function.
- One sub-module, `puf_vote_acc`: per-bit majority counters with clear, accumulate and result outputs. It is instantiated only under the macro.

## Test plan
- Reset mid-PULSE: assert `rst` → `pulse_o`, `busy`, `resp_valid` go to 0 asynchronously, before the next clock edge. After release, IDLE.
- `seed`=0, `num_chal`=4, `resp_ready` tied 1, `response_i`=7'h55 → four pairs with challenges 0x01, 0x02, 0x04, 0x08, each `resp_data` = {chal, 0, 7'h55}. `done` one cycle after the 4th.
- `seed`=0x08, `num_chal`=2 → challenges 0x08 then 0x11. Check `challenge_o` is stable across every PULSE and HOLD cycle.
- Backpressure: `resp_ready`=0 for 20 cycles in PRESENT → `resp_valid` and `resp_data` are held; no new `pulse_o` activity.
- Vote (macro on, REPEATS=5): response bit0 = 1,1,0,0,1 across evaluations → result bit0=1. Pattern 0,1,0,1,0 → 0.
- `abort` during HOLD of challenge 2 → IDLE next cycle, no `resp_valid`, no `done`. A fresh `start` restarts from `seed`.
